// File: rtl/reg_wire_pipe_pkg.sv
// reg_wire_pipe_pkg
// Shared types and constants for the reg_wire_pipe channel stage.
//   mode_e    : per-channel mode state (registered, draining, wire)
//   STATS_W   : width of the per-channel transfer counter (PORT_STATS_EN)
//   wrap_inc  : modulo-DEPTH pointer increment (DEPTH need not be a power of two)
package reg_wire_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_REG   = 2'd0,
    MODE_DRAIN = 2'd1,
    MODE_BYP   = 2'd2
  } mode_e;

  localparam int STATS_W = 16;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/reg_wire_pipe_if.sv
// reg_wire_pipe_if
// Bundles all per-channel stream, mode and status buses of reg_wire_pipe.
// Channel c occupies bit c of the 1-bit-per-channel buses, bits
// [c*WIDTH +: WIDTH] of the data buses and [c*OCC_W +: OCC_W] of occupancy.
//   master : the side driving upstream data, downstream ready and mode requests
//   slave  : the reg_wire_pipe block itself
// Optional feature macro: PORT_STATS_EN adds stats_clr / xfer_count.
interface reg_wire_pipe_if
  import reg_wire_pipe_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       bypass_req;
  logic [CHANNELS-1:0]       bypass_mode;
  logic [CHANNELS*OCC_W-1:0] occupancy;
`ifdef PORT_STATS_EN
  logic                        stats_clr;
  logic [CHANNELS*STATS_W-1:0] xfer_count;

  modport master (
    output in_valid, in_data, out_ready, bypass_req, stats_clr,
    input  in_ready, out_valid, out_data, bypass_mode, occupancy, xfer_count
  );
  modport slave (
    input  in_valid, in_data, out_ready, bypass_req, stats_clr,
    output in_ready, out_valid, out_data, bypass_mode, occupancy, xfer_count
  );
`else
  modport master (
    output in_valid, in_data, out_ready, bypass_req,
    input  in_ready, out_valid, out_data, bypass_mode, occupancy
  );
  modport slave (
    input  in_valid, in_data, out_ready, bypass_req,
    output in_ready, out_valid, out_data, bypass_mode, occupancy
  );
`endif

endinterface

// File: rtl/reg_wire_pipe_chan.sv
// reg_wire_pipe_chan
// One channel of reg_wire_pipe: mode state machine (REG/DRAIN/BYP), a
// DEPTH-entry elastic queue used in registered mode, and (with the
// PORT_STATS_EN macro) a saturating downstream-handshake counter.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data  upstream stream
//   out_valid/out_ready/out_data downstream stream
//   bypass_req                 1 = request wire mode
//   bypass_mode                1 = currently in wire mode
//   occupancy                  queue fill level
//   stats_clr, xfer_count      counter clear / value (PORT_STATS_EN only)
module reg_wire_pipe_chan
  import reg_wire_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             bypass_req,
  output logic             bypass_mode,
  output logic [OCC_W-1:0] occupancy
`ifdef PORT_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [STATS_W-1:0] xfer_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  mode_e            state_reg, state_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             q_empty, q_full;
  logic             push, pop;

  assign q_empty = (occ_reg == '0);
  assign q_full  = (occ_reg == OCC_W'(DEPTH));

  // Mode state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MODE_REG;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MODE_REG:   if (bypass_req) state_next = MODE_DRAIN;
      MODE_DRAIN: begin
        if (!bypass_req)  state_next = MODE_REG;
        else if (q_empty) state_next = MODE_BYP;
      end
      MODE_BYP:   if (!bypass_req) state_next = MODE_REG;
      default:    state_next = MODE_REG;
    endcase
  end

  // Stream outputs. In registered mode in_ready ignores out_ready, so a
  // full queue refuses a push even in a popping cycle.
  always_comb begin
    in_ready  = !q_full;
    out_valid = !q_empty;
    out_data  = mem_reg[rd_ptr_reg];
    case (state_reg)
      MODE_DRAIN: in_ready = 1'b0;
      MODE_BYP: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
      end
      default: ;
    endcase
  end

  assign bypass_mode = (state_reg == MODE_BYP);
  assign occupancy   = occ_reg;

  // Wire mode leaves the queue untouched.
  assign push = in_valid  && in_ready  && (state_reg != MODE_BYP);
  assign pop  = out_valid && out_ready && (state_reg != MODE_BYP);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= PTR_W'(wrap_inc(32'(wr_ptr_reg), DEPTH));
      if (pop)  rd_ptr_reg <= PTR_W'(wrap_inc(32'(rd_ptr_reg), DEPTH));
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Queue storage, one register per entry so reset can clear it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= in_data;
      end
    end
  end

`ifdef PORT_STATS_EN
  // Counts every downstream handshake in any mode; saturates at all-ones.
  logic [STATS_W-1:0] xfer_count_reg;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      xfer_count_reg <= '0;
    end else if (out_valid && out_ready && (xfer_count_reg != '1)) begin
      xfer_count_reg <= xfer_count_reg + 1'b1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: rtl/reg_wire_pipe.sv
// reg_wire_pipe
// Multi-channel data stage: each channel runs independently in registered
// mode (elastic queue) or wire mode (combinational pass-through), with a
// drain state machine making mode changes lossless. This level only unpacks
// and packs the channel buses.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         reg_wire_pipe_if.slave: all per-channel stream/mode/status buses
// Optional feature macro: PORT_STATS_EN (per-channel transfer counters).
module reg_wire_pipe
  import reg_wire_pipe_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  reg_wire_pipe_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    reg_wire_pipe_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (bus.in_valid[gi]),
      .in_ready    (bus.in_ready[gi]),
      .in_data     (bus.in_data[gi*WIDTH +: WIDTH]),
      .out_valid   (bus.out_valid[gi]),
      .out_ready   (bus.out_ready[gi]),
      .out_data    (bus.out_data[gi*WIDTH +: WIDTH]),
      .bypass_req  (bus.bypass_req[gi]),
      .bypass_mode (bus.bypass_mode[gi]),
      .occupancy   (bus.occupancy[gi*OCC_W +: OCC_W])
`ifdef PORT_STATS_EN
      ,
      .stats_clr   (bus.stats_clr),
      .xfer_count  (bus.xfer_count[gi*STATS_W +: STATS_W])
`endif
    );
  end

endmodule

// File: tb/tb_reg_wire_pipe.sv
// tb_reg_wire_pipe
// Scoreboard bench for reg_wire_pipe. A behavioural model (mode per channel,
// fill count, SV queue of expected words) advances on each rising edge; a
// separate monitor on the falling edge compares the DUT outputs against it
// and pops the expected word for every downstream handshake.
module tb_reg_wire_pipe;

  localparam int CH    = 2;
  localparam int W     = 8;
  localparam int D     = 2;
  localparam int OCC_W = $clog2(D + 1);

  localparam int M_REG   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_BYP   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CH-1:0]   in_valid;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   out_ready;
  logic [CH-1:0]   bypass_req;

  reg_wire_pipe_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) bus ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.out_ready  = out_ready;
  assign bus.bypass_req = bypass_req;
`ifdef PORT_STATS_EN
  logic stats_clr;
  assign bus.stats_clr = stats_clr;
`endif

  reg_wire_pipe #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  int         m_mode [CH];
  int         m_occ  [CH];
  int         m_xfer [CH];
  logic [W-1:0] sb_q [CH][$];
  bit         model_ok = 1'b0;
  bit         quiet    = 1'b0;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h at %0t", name, c, act, exp, $time);
    end
  endtask

  function automatic bit exp_in_ready(input int c);
    case (m_mode[c])
      M_REG:   return m_occ[c] < D;
      M_DRAIN: return 1'b0;
      default: return out_ready[c];
    endcase
  endfunction

  function automatic bit exp_out_valid(input int c);
    if (m_mode[c] == M_BYP) return in_valid[c];
    return m_occ[c] > 0;
  endfunction

  function automatic string mode_name(input int m);
    case (m)
      M_REG:   return "REG";
      M_DRAIN: return "DRAIN";
      default: return "BYP";
    endcase
  endfunction

  // Model update: effect of each rising edge, from the inputs held before it.
  always @(posedge clk) begin
    if (reset) begin
      model_ok = 1'b1;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = M_REG;
        m_occ[c]  = 0;
        m_xfer[c] = 0;
        sb_q[c].delete();
      end
    end else if (model_ok) begin
      for (int c = 0; c < CH; c++) begin
        bit ir, ov, pu, po;
        int nm;
        ir = exp_in_ready(c);
        ov = exp_out_valid(c);
        pu = in_valid[c] && ir && (m_mode[c] != M_BYP);
        po = ov && out_ready[c] && (m_mode[c] != M_BYP);
`ifdef PORT_STATS_EN
        if (stats_clr) m_xfer[c] = 0;
        else if (ov && out_ready[c] && m_xfer[c] < 65535) m_xfer[c]++;
`endif
        nm = m_mode[c];
        if (m_mode[c] == M_REG && bypass_req[c]) nm = M_DRAIN;
        else if (m_mode[c] == M_DRAIN && !bypass_req[c]) nm = M_REG;
        else if (m_mode[c] == M_DRAIN && m_occ[c] == 0) nm = M_BYP;
        else if (m_mode[c] == M_BYP && !bypass_req[c]) nm = M_REG;
        if (pu) sb_q[c].push_back(in_data[c*W +: W]);
        m_occ[c] = m_occ[c] + int'(pu) - int'(po);
        m_mode[c] = nm;
      end
    end
  end

  // Monitor: compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int c = 0; c < CH; c++) begin
        check("in_ready",    c, 32'(bus.in_ready[c]),    32'(exp_in_ready(c)));
        check("out_valid",   c, 32'(bus.out_valid[c]),   32'(exp_out_valid(c)));
        check("bypass_mode", c, 32'(bus.bypass_mode[c]), 32'(m_mode[c] == M_BYP));
        check("occupancy",   c, 32'(bus.occupancy[c*OCC_W +: OCC_W]), 32'(m_occ[c]));
`ifdef PORT_STATS_EN
        check("xfer_count",  c, 32'(bus.xfer_count[c*16 +: 16]), 32'(m_xfer[c]));
`endif
        if (bus.out_valid[c] === 1'b1) begin
          if (m_mode[c] == M_BYP) begin
            check("byp_data", c, 32'(bus.out_data[c*W +: W]), 32'(in_data[c*W +: W]));
            if (out_ready[c] && !quiet)
              $display("xfer ch%0d data=0x%02h mode=%s", c, bus.out_data[c*W +: W], mode_name(m_mode[c]));
          end else if (sb_q[c].size() > 0) begin
            check("head_data", c, 32'(bus.out_data[c*W +: W]), 32'(sb_q[c][0]));
            if (out_ready[c]) begin
              void'(sb_q[c].pop_front());
              if (!quiet)
                $display("xfer ch%0d data=0x%02h mode=%s", c, bus.out_data[c*W +: W], mode_name(m_mode[c]));
            end
          end else begin
            check("spurious_valid", c, 32'(bus.out_valid[c]), 32'(0));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = '0;
    bypass_req = '0;
`ifdef PORT_STATS_EN
    stats_clr  = 1'b0;
`endif
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      check("rst_out_data",  c, 32'(bus.out_data[c*W +: W]), 32'(0));
      check("rst_out_valid", c, 32'(bus.out_valid[c]), 32'(0));
      check("rst_in_ready",  c, 32'(bus.in_ready[c]), 32'(1));
    end
    step();

    // Fill channel 0 with downstream stalled: third word must be refused.
    in_valid[0] = 1'b1; in_data[7:0] = 8'h11; step();
    in_data[7:0] = 8'h22; step();
    in_data[7:0] = 8'h33; step();
    @(negedge clk);
    check("full_in_ready", 0, 32'(bus.in_ready[0]), 32'(0));
    check("full_occ",      0, 32'(bus.occupancy[OCC_W-1:0]), 32'(2));
    step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    repeat (3) step();

    // Queue two words, then request wire mode: drain, then pass-through.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[7:0] = 8'hAA; step();
    in_data[7:0] = 8'hBB; step();
    in_valid[0] = 1'b0; bypass_req[0] = 1'b1; step();
    out_ready[0] = 1'b1;
    repeat (4) step();
    in_valid[0] = 1'b1; in_data[7:0] = 8'hA5;
    @(negedge clk);
    check("byp_mode",  0, 32'(bus.bypass_mode[0]), 32'(1));
    check("byp_a5",    0, 32'(bus.out_data[7:0]), 32'(8'hA5));
    step();

    // Leave wire mode while upstream is presenting a word.
    out_ready[0] = 1'b0; in_data[7:0] = 8'h5A; bypass_req[0] = 1'b0; step();
    @(negedge clk);
    check("reg_first_in_ready",  0, 32'(bus.in_ready[0]), 32'(1));
    check("reg_first_out_valid", 0, 32'(bus.out_valid[0]), 32'(0));
    step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    repeat (3) step();

    // Opposite modes on the two channels, traffic on both, reset mid-burst.
    bypass_req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c]        = ($urandom_range(0, 3) != 0);
        in_data[c*W +: W]  = W'($urandom);
        out_ready[c]       = (c == 1) ? ($urandom_range(0, 3) != 0) : (i > 20);
      end
      step();
    end
    reset = 1'b1; step();
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      check("midrst_occ",       c, 32'(bus.occupancy[c*OCC_W +: OCC_W]), 32'(0));
      check("midrst_out_valid", c, 32'(bus.out_valid[c]), 32'(0));
    end
    step();

    // Randomised soak with occasional mode flips and one reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c]       = ($urandom_range(0, 3) != 0);
        in_data[c*W +: W] = W'($urandom);
        out_ready[c]      = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 24) == 0) bypass_req[c] = ~bypass_req[c];
      end
      reset = (i == 1500);
      step();
    end
    reset = 1'b0;

`ifdef PORT_STATS_EN
    // Saturate channel 1's counter, then clear it.
    quiet = 1'b1;
    in_valid = '0; out_ready = '0; bypass_req = '0;
    reset = 1'b1; step(); reset = 1'b0;
    bypass_req[1] = 1'b1; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      in_data[W +: W] = W'(i);
      step();
    end
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("xfer_sat", 1, 32'(bus.xfer_count[31:16]), 32'(16'hFFFF));
    step();
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    @(negedge clk);
    check("xfer_clr", 1, 32'(bus.xfer_count[31:16]), 32'(0));
    quiet = 1'b0;
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_wire_pipe.md
# reg_wire_pipe

Parametrised multi-channel data stage. Each channel carries a valid/ready stream and runs in one of two modes. Registered mode buffers data in a small elastic queue. Wire mode is a zero-latency combinational pass-through. Mode changes are safe and controlled by a per-channel drain state machine. The block sits between port-level wrappers and core logic wherever a channel must switch between registered and direct connection at run time.

## Interface
Parameters:
- CHANNELS, 2, number of independent channels (≥1)
- WIDTH, 8, data bits per channel (≥1)
- DEPTH, 2, registered-mode queue entries per channel (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  CHANNELS  per-channel upstream valid
- in_ready  out  CHANNELS  per-channel upstream ready
- in_data  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  per-channel downstream valid
- out_ready  in  CHANNELS  per-channel downstream ready
- out_data  out  CHANNELS*WIDTH  same packing as in_data
- bypass_req  in  CHANNELS  1 = request wire mode, 0 = request registered mode
- bypass_mode  out  CHANNELS  1 = channel currently in wire mode (registered output)
- occupancy  out  CHANNELS*$clog2(DEPTH+1)  per-channel queue fill level
- stats_clr  in  1  clears all transfer counters (only with PORT_STATS_EN)
- xfer_count  out  CHANNELS*16  per-channel downstream handshake count (only with PORT_STATS_EN)

## Operation
- Channels are fully independent. There is no shared arbitration.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Per-channel state machine has three states: REG, DRAIN, BYP.
  - REG: bypass_req=1 → DRAIN. Otherwise stay.
  - DRAIN: bypass_req=0 → REG. Otherwise, when occupancy==0 → BYP. Otherwise stay.
  - BYP: bypass_req=0 → REG. Otherwise stay.
- REG behaviour:
  - in_ready = (occupancy < DEPTH). This does not depend on out_ready: a full queue refuses a push even in a cycle that pops.
  - out_valid = (occupancy > 0). out_data = head entry.
- DRAIN behaviour:
  - in_ready = 0. Pops continue exactly as in REG.
- BYP behaviour:
  - out_valid = in_valid, out_data = in_data, in_ready = out_ready, all combinational.
  - The queue is untouched and stays empty.
- Queue mechanics:
  - Write pointer and read pointer each count 0..DEPTH-1 and wrap to 0. DEPTH need not be a power of two.
  - Occupancy is updated as follows:
    - push without pop: +1
    - pop without push: −1
    - push and pop together: unchanged, and both pointers advance.
- bypass_mode = 1 only in BYP.

## Timing
- Reset values: state REG, occupancy 0, pointers 0, all queue entries 0. Resulting outputs: out_valid 0, out_data 0, in_ready 1, bypass_mode 0, xfer_count 0.
- A reset asserted mid-operation discards all queued data in the same edge. No pop is signalled for the discarded entries.
- REG latency: data pushed at edge N is visible on out_valid/out_data after edge N. Minimum latency is 1 cycle.
- BYP latency: 0 cycles.
- Mode-switch timing:
  - REG→DRAIN takes effect on the edge after bypass_req rises.
  - DRAIN→BYP takes one edge after occupancy reaches 0. At least one cycle shows in_ready=0 and out_valid=0 before BYP.
  - BYP→REG takes effect on the edge after bypass_req falls. In that first REG cycle, in_ready=1 and out_valid=0.
- No data is lost or reordered across any mode transition.

## Configuration
- Macro: PORT_STATS_EN.
- Defined:
  - Per-channel 16-bit counter increments on each downstream handshake, in any state.
  - The counter saturates at 0xFFFF.
  - stats_clr=1 zeroes all counters on the next edge, with priority over increment.
  - reset zeroes the counters.
- Undefined: stats_clr and xfer_count ports and all counter logic are absent.

## Structure
- Package reg_wire_pipe_pkg holds:
  - the mode-state enum (MODE_REG, MODE_DRAIN, MODE_BYP)
  - the constant STATS_W = 16
- Sub-module reg_wire_pipe_chan contains one channel: state machine, queue and optional counter. The top level instantiates CHANNELS copies in a generate loop and handles only bus packing.

## Test plan
- Reset then idle → out_valid=0, in_ready all 1, occupancy 0, out_data 0 on every channel.
- Channel 0 in REG, DEPTH=2, push 0x11, 0x22, 0x33 with out_ready=0 → only 0x11 and 0x22 accepted, in_ready=0 at occupancy 2. Then out_ready=1 → 0x11, 0x22 emerge in order.
- Channel 0 REG with 2 queued, raise bypass_req → in_ready=0 while draining, 2 pops, then bypass_mode=1. Drive 0xA5 in → out_data=0xA5 in the same cycle.
- BYP, drop bypass_req while in_valid=1 → next cycle REG, push 0x5A with 1-cycle latency, no duplicate output.
- Channels 0 and 1 with opposite modes and simultaneous traffic → no cross-channel interference. Assert reset mid-burst → occupancy 0 and out_valid 0 after the edge.
- With PORT_STATS_EN, 70000 handshakes on channel 1 → xfer_count=0xFFFF. stats_clr pulse → 0.
